// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// Key-length codes, round counts and the controller state encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;
  localparam logic [1:0] KEYLEN_BAD = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // An illegal code returns 0; callers reject that code before using the result.
  function automatic logic [3:0] nr_for_keylen(input logic [1:0] key_len);
    logic [3:0] nr;
    nr = 4'd0;
    case (key_len)
      KEYLEN_128: nr = NR_128;
      KEYLEN_192: nr = NR_192;
      KEYLEN_256: nr = NR_256;
      default:    nr = 4'd0;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round index / in-round cycle counter for the AES round controller.
// idx runs 1..nr and holds at nr; cnt wraps every rc cycles.
module aes_round_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [3:0] nr,
  input  logic [2:0] rc,
  output logic [3:0] idx,
  output logic       start,
  output logic       last
);

  logic [2:0] cnt;

  assign start = (cnt == 3'd0);
  assign last  = (cnt == rc - 3'd1);

  // Clear parks the counter at the first cycle of round 1, ready for the next block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 4'd1;
      cnt <= 3'd0;
    end else if (clear) begin
      idx <= 4'd1;
      cnt <= 3'd0;
    end else if (en) begin
      if (last) begin
        cnt <= 3'd0;
        if (idx != nr) idx <= idx + 4'd1;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a block, steps the datapath through NR rounds of
// RC cycles each, then presents the result until the consumer takes it.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int RC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] key_len,
  input  logic       abort,
  output logic       dp_load,
  output logic       dp_round_start,
  output logic [3:0] dp_round,
  output logic       dp_final,
  output logic       dp_capture,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       cfg_err,
  output logic       busy
);

  localparam logic [2:0] RC_CYCLES = 3'(RC);

  state_t     state;
  logic       armed;
  logic [3:0] nr_q;
  logic [3:0] idx;
  logic       start;
  logic       last;
  logic       in_round;

  assign in_round = (state == ROUND);

  // armed keeps in_ready low until the first edge after reset is released.
  assign in_ready = armed && (state == IDLE);

  aes_round_counter u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_round),
    .en    (in_round),
    .nr    (nr_q),
    .rc    (RC_CYCLES),
    .idx   (idx),
    .start (start),
    .last  (last)
  );

  // The dp_* strobes trail the state by one cycle, which gives the fixed
  // 2 + NR*RC accept-to-out_valid latency; busy tracks the state directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      armed          <= 1'b0;
      nr_q           <= 4'd0;
      dp_load        <= 1'b0;
      dp_round_start <= 1'b0;
      dp_round       <= 4'd0;
      dp_final       <= 1'b0;
      dp_capture     <= 1'b0;
      out_valid      <= 1'b0;
      cfg_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      armed          <= 1'b1;
      cfg_err        <= 1'b0;
      dp_load        <= (state == LOAD);
      dp_round_start <= in_round && start;
      dp_capture     <= in_round && last;
      dp_round       <= in_round ? idx : 4'd0;
      dp_final       <= in_round && (idx == nr_q);

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (key_len == KEYLEN_BAD) begin
              cfg_err <= 1'b1;
            end else begin
              nr_q  <= nr_for_keylen(key_len);
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
        end
        LOAD: state <= ROUND;
        ROUND: begin
          if (last && (idx == nr_q)) state <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort wins over capture and the out_valid handshake alike.
      if (abort && (state != IDLE)) begin
        state          <= IDLE;
        busy           <= 1'b0;
        out_valid      <= 1'b0;
        dp_load        <= 1'b0;
        dp_round_start <= 1'b0;
        dp_round       <= 4'd0;
        dp_final       <= 1'b0;
        dp_capture     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: one RC=2 instance and one RC=3 instance
// sharing everything except in_valid.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv2 = 1'b0;
  logic       iv3 = 1'b0;
  logic [1:0] key_len = 2'b00;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready2, dp_load2, dp_start2, dp_final2, dp_cap2, out_valid2, cfg_err2, busy2;
  logic [3:0] dp_round2;
  logic       in_ready3, dp_load3, dp_start3, dp_final3, dp_cap3, out_valid3, cfg_err3, busy3;
  logic [3:0] dp_round3;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.RC(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(in_ready2), .key_len(key_len),
    .abort(abort), .dp_load(dp_load2), .dp_round_start(dp_start2), .dp_round(dp_round2),
    .dp_final(dp_final2), .dp_capture(dp_cap2), .out_valid(out_valid2),
    .out_ready(out_ready), .cfg_err(cfg_err2), .busy(busy2)
  );

  aes_round_ctrl #(.RC(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(in_ready3), .key_len(key_len),
    .abort(abort), .dp_load(dp_load3), .dp_round_start(dp_start3), .dp_round(dp_round3),
    .dp_final(dp_final3), .dp_capture(dp_cap3), .out_valid(out_valid3),
    .out_ready(out_ready), .cfg_err(cfg_err3), .busy(busy3)
  );

  // One active edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    compared++; if (in_ready2 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready2); end
    compared++; if (busy2 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy2); end
    compared++; if ({dp_load2, dp_round2, out_valid2, cfg_err2} !== 7'd0) begin mismatched++; $display("[TB] FAIL reset_outputs: got %b expected 0", {dp_load2, dp_round2, out_valid2, cfg_err2}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    compared++; if (in_ready2 !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_release_in_ready: got %b expected 1", in_ready2); end
  endtask

  // AES-128 on RC=2: full cycle-by-cycle trace up to out_valid at T0+22.
  task automatic test_aes128();
    logic [3:0] er;
    int caps;
    caps = 0;
    key_len = 2'b00; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    compared++; if (busy2 !== 1'b1 || in_ready2 !== 1'b0) begin mismatched++; $display("[TB] FAIL accept128: busy=%b in_ready=%b expected 1/0", busy2, in_ready2); end
    compared++; if (dp_load2 !== 1'b0) begin mismatched++; $display("[TB] FAIL load_early128: got %b expected 0", dp_load2); end
    for (int c = 1; c <= 22; c++) begin
      tick();
      er = (c >= 2 && c <= 21) ? 4'(c / 2) : 4'd0;
      if (dp_cap2 === 1'b1) caps++;
      compared++; if (dp_round2 !== er) begin mismatched++; $display("[TB] FAIL round128 c=%0d: got %0d expected %0d", c, dp_round2, er); end
      compared++; if (dp_load2 !== (c == 1)) begin mismatched++; $display("[TB] FAIL load128 c=%0d: got %b expected %b", c, dp_load2, (c == 1)); end
      compared++; if (dp_start2 !== (er != 0 && c % 2 == 0)) begin mismatched++; $display("[TB] FAIL start128 c=%0d: got %b", c, dp_start2); end
      compared++; if (dp_cap2 !== (er != 0 && c % 2 == 1)) begin mismatched++; $display("[TB] FAIL capture128 c=%0d: got %b", c, dp_cap2); end
      compared++; if (dp_final2 !== (er == 4'd10)) begin mismatched++; $display("[TB] FAIL final128 c=%0d: got %b", c, dp_final2); end
      compared++; if (out_valid2 !== (c == 22)) begin mismatched++; $display("[TB] FAIL out_valid128 c=%0d: got %b expected %b", c, out_valid2, (c == 22)); end
    end
    compared++; if (caps != 10) begin mismatched++; $display("[TB] FAIL captures128: got %0d expected 10", caps); end
  endtask

  // Consumer stalls, then takes the result; a second block follows immediately.
  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      compared++; if (out_valid2 !== 1'b1 || dp_round2 !== 4'd0 || dp_cap2 !== 1'b0 || dp_load2 !== 1'b0) begin mismatched++; $display("[TB] FAIL done_hold c=%0d: out_valid=%b round=%0d", c, out_valid2, dp_round2); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++; if (out_valid2 !== 1'b0 || busy2 !== 1'b0 || in_ready2 !== 1'b1) begin mismatched++; $display("[TB] FAIL done_exit: out_valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid2, busy2, in_ready2); end
    key_len = 2'b00; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    compared++; if (busy2 !== 1'b1) begin mismatched++; $display("[TB] FAIL second_accept: busy got %b expected 1", busy2); end
  endtask

  // Abort exactly when round 5 captures; the block must vanish.
  task automatic test_abort();
    for (int c = 1; c <= 11; c++) tick();
    compared++; if (dp_round2 !== 4'd5 || dp_cap2 !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_setup: round=%0d capture=%b expected 5/1", dp_round2, dp_cap2); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++; if (dp_round2 !== 4'd0 || dp_cap2 !== 1'b0 || busy2 !== 1'b0 || in_ready2 !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_idle: round=%0d cap=%b busy=%b in_ready=%b", dp_round2, dp_cap2, busy2, in_ready2); end
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 25; c++) begin
        tick();
        if (out_valid2 === 1'b1 || busy2 === 1'b1) seen++;
      end
      compared++; if (seen != 0) begin mismatched++; $display("[TB] FAIL abort_no_output: active cycles got %0d expected 0", seen); end
    end
  endtask

  task automatic test_cfg_err();
    key_len = 2'b11; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    compared++; if (cfg_err2 !== 1'b1 || busy2 !== 1'b0) begin mismatched++; $display("[TB] FAIL cfg_err_pulse: cfg_err=%b busy=%b expected 1/0", cfg_err2, busy2); end
    tick();
    compared++; if (cfg_err2 !== 1'b0 || dp_load2 !== 1'b0 || busy2 !== 1'b0 || in_ready2 !== 1'b1) begin mismatched++; $display("[TB] FAIL cfg_err_after: cfg_err=%b load=%b busy=%b", cfg_err2, dp_load2, busy2); end
  endtask

  // Abort in IDLE must not block the handshake; then reset kills round 7.
  task automatic test_reset_mid_round();
    logic [3:0] er;
    key_len = 2'b00; abort = 1'b1; iv2 = 1'b1;
    tick();
    abort = 1'b0; iv2 = 1'b0;
    compared++; if (busy2 !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_idle_accept: busy got %b expected 1", busy2); end
    for (int c = 1; c <= 14; c++) tick();
    compared++; if (dp_round2 !== 4'd7) begin mismatched++; $display("[TB] FAIL reset_setup: round got %0d expected 7", dp_round2); end
    rst = 1'b1;
    #1;
    compared++; if ({dp_round2, busy2, in_ready2, dp_start2, dp_final2} !== 8'd0) begin mismatched++; $display("[TB] FAIL async_reset: got %b expected 0", {dp_round2, busy2, in_ready2, dp_start2, dp_final2}); end
    #1;
    rst = 1'b0;
    tick();
    compared++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_recover: in_ready=%b out_valid=%b expected 1/0", in_ready2, out_valid2); end
    iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      er = (c >= 2 && c <= 21) ? 4'(c / 2) : 4'd0;
      if (c == 15 || c == 21 || c == 22) begin
        compared++; if (dp_round2 !== er || out_valid2 !== (c == 22)) begin mismatched++; $display("[TB] FAIL rerun c=%0d: round=%0d out_valid=%b expected %0d/%b", c, dp_round2, out_valid2, er, (c == 22)); end
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++; if (out_valid2 !== 1'b0 || busy2 !== 1'b0) begin mismatched++; $display("[TB] FAIL rerun_exit: out_valid=%b busy=%b", out_valid2, busy2); end
  endtask

  // AES-256 on RC=3: 14 rounds of 3 cycles, out_valid at T0+44.
  task automatic test_aes256();
    logic [3:0] er;
    int caps;
    int maxr;
    caps = 0; maxr = 0;
    key_len = 2'b10; iv3 = 1'b1;
    tick();
    iv3 = 1'b0; key_len = 2'b00;
    for (int c = 1; c <= 44; c++) begin
      tick();
      er = (c >= 2 && c <= 43) ? 4'((c - 2) / 3 + 1) : 4'd0;
      if (dp_cap3 === 1'b1) caps++;
      if (int'(dp_round3) > maxr) maxr = int'(dp_round3);
      compared++; if (dp_round3 !== er) begin mismatched++; $display("[TB] FAIL round256 c=%0d: got %0d expected %0d", c, dp_round3, er); end
      compared++; if (dp_final3 !== (er == 4'd14)) begin mismatched++; $display("[TB] FAIL final256 c=%0d: got %b", c, dp_final3); end
      compared++; if (out_valid3 !== (c == 44)) begin mismatched++; $display("[TB] FAIL out_valid256 c=%0d: got %b expected %b", c, out_valid3, (c == 44)); end
    end
    compared++; if (caps != 14) begin mismatched++; $display("[TB] FAIL captures256: got %0d expected 14", caps); end
    compared++; if (maxr != 14) begin mismatched++; $display("[TB] FAIL maxround256: got %0d expected 14", maxr); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin mismatched++; $display("[TB] FAIL exit256: out_valid=%b in_ready=%b", out_valid3, in_ready3); end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_back_to_back();
    test_abort();
    test_cfg_err();
    test_reset_mid_round();
    test_aes256();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter RC, default 2, SHALL be the datapath clock cycles per round; the mixcolumns stage is registered, so 2 is the minimum; legal range 2..7.
REQ-002 clk  in  1  SHALL be the single clock; all logic on posedge.
REQ-003 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  in  1  SHALL mean a block and key are ready for processing.
REQ-005 in_ready  out  1  SHALL mean the controller accepts a new block.
REQ-006 key_len  in  2  SHALL select the key size, sampled at the in_valid&in_ready handshake: 00=AES-128 (NR=10), 01=AES-192 (NR=12), 10=AES-256 (NR=14), 11=illegal.
REQ-007 abort  in  1  SHALL request a synchronous return to IDLE.
REQ-008 dp_load  out  1  SHALL tell the datapath to load the plaintext and apply round-0 addroundkey.
REQ-009 dp_round_start  out  1  SHALL mark the first cycle of each round.
REQ-010 dp_round  out  4  SHALL give the current round index, 1..NR, and 0 outside rounds.
REQ-011 dp_final  out  1  SHALL tell the datapath to bypass mixcolumns (round NR only).
REQ-012 dp_capture  out  1  SHALL tell the datapath to register the round result (last cycle of each round).
REQ-013 out_valid  out  1  SHALL mean the ciphertext in the datapath is final.
REQ-014 out_ready  in  1  SHALL mean the consumer takes the ciphertext.
REQ-015 cfg_err  out  1  SHALL be a one-cycle pulse when key_len=11 is offered.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, ROUND, DONE.
REQ-018 IDLE SHALL drive in_ready=1; on a handshake with a legal key_len, the FSM SHALL latch NR and go to LOAD.
REQ-019 A handshake with key_len=11 SHALL pulse cfg_err the next cycle and leave the FSM in IDLE.
REQ-020 LOAD SHALL last exactly 1 cycle with dp_load=1, then enter ROUND with dp_round=1 and a cycle counter of 0.
REQ-021 ROUND SHALL hold each round index for RC cycles:
- dp_round_start=1 when the counter is 0;
- dp_capture=1 when the counter is RC-1;
- on capture the counter SHALL wrap to 0 and dp_round SHALL increment.
REQ-022 dp_final SHALL equal (dp_round==NR) throughout round NR.
REQ-023 Capture in round NR SHALL move the FSM to DONE.
REQ-024 Latency SHALL be fixed: out_valid first high exactly 2+NR*RC cycles after the accept edge (22 for NR=10, RC=2).
REQ-025 DONE SHALL hold out_valid=1 until out_ready=1; that handshake edge SHALL return the FSM to IDLE, so in_ready rises the next cycle (no same-cycle re-accept).
REQ-026 abort in any non-IDLE state SHALL force IDLE on the next edge and clear all dp_* outputs. abort SHALL override a simultaneous out_ready or capture. abort in IDLE SHALL have no effect and SHALL NOT block a same-cycle handshake.
REQ-027 in_valid while busy SHALL be ignored.
REQ-028 All outputs except in_ready SHALL be registered. in_ready SHALL be decoded from the state only, with no combinational path from any input.

Reset
REQ-029 While rst=1, the FSM SHALL be IDLE and in_ready, out_valid, busy, cfg_err and all dp_* outputs SHALL be 0.
REQ-030 Reset SHALL be asserted asynchronously; in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-031 Reset mid-round SHALL discard the block; no out_valid SHALL follow.

Structure
REQ-032 A shared package aes_pkg SHALL hold:
- the state enum;
- KEYLEN_128/192/256 codes;
- NR_128=10, NR_192=12, NR_256=14.
REQ-033 The round/cycle counter SHALL be a sub-module aes_round_counter (inputs: clear, NR, RC; outputs: idx, start, last).

Verification
REQ-034 AES-128, RC=2: accept at edge T0 -> dp_load at T0+1; dp_round sequence 1,1,2,2,...,10,10; dp_final only for round 10; out_valid at T0+22; ciphertext matches FIPS-197 (key 000102..0f, plaintext 00112233..ff -> 69c4e0d8..c55a) with the mixcolumns datapath attached.
REQ-035 AES-256, RC=3: out_valid at T0+44; dp_round reaches 14; exactly 14 dp_capture pulses.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1 and dp_* stay 0; out_ready=1 -> IDLE next edge; a back-to-back second block is accepted one cycle later.
REQ-037 key_len=11 offered -> one cfg_err pulse, busy stays 0, no dp_load.
REQ-038 abort at dp_round=5 coincident with dp_capture -> IDLE next edge, dp_round=0, no out_valid.
REQ-039 rst pulsed asynchronously mid-round 7 -> all outputs 0 immediately; next block runs at full latency.
